// File: rtl/neuron_frame_loader_if.sv
// neuron_frame_loader_if
//   Stream-in / frame-out bundle for neuron_frame_loader.
//   in_data/in_valid/in_ready : one 8-bit activation per accepted cycle
//   out_data/out_valid/out_ready : complete frame, entry 0 = first value taken
//   fill_count : entries written into the frame being built (0..neurons)
//   Modports: slave = the loader, master = the producer/consumer side.
interface neuron_frame_loader_if #(
  parameter int neurons = 8
);
  localparam int IDXW = (neurons > 1) ? $clog2(neurons) : 1;

  logic [7:0]                 in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [0:neurons-1][7:0]    out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [IDXW:0]              fill_count;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, fill_count
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, fill_count
  );
endinterface

// File: rtl/neuron_frame_loader.sv
// neuron_frame_loader
//   Serial-to-parallel packer: collects `neurons` 8-bit activations into a
//   frame register and holds the complete frame for the reduction stage.
//   Ports:
//     clock  : rising-edge clock
//     reset  : synchronous active-high reset (clears state and frame data)
//     enable : when low, no input is accepted
//     clear  : synchronous frame abort (frame data retained)
//     bus    : neuron_frame_loader_if.slave (stream in, frame out, fill_count)
//   Optional (macro NEURON_FRAME_LOADER_MAX_TRACK_EN):
//     max_val/max_idx : running maximum of the frame and its lowest index
module neuron_frame_loader #(
  parameter int neurons = 8,
  localparam int IDXW = (neurons > 1) ? $clog2(neurons) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  neuron_frame_loader_if.slave  bus
`ifdef NEURON_FRAME_LOADER_MAX_TRACK_EN
  ,
  output logic [7:0]            max_val,
  output logic [IDXW-1:0]       max_idx
`endif
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [IDXW:0]           fill_q, fill_nxt;
  logic [0:neurons-1][7:0] data_q;
  logic                    accept, handshake, last;

  assign bus.in_ready   = (state == FILL) && enable;
  assign bus.out_valid  = (state == FULL);
  assign bus.out_data   = data_q;
  assign bus.fill_count = fill_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign handshake = (state == FULL) && bus.out_ready;
  assign last      = (fill_q == (IDXW+1)'(neurons - 1));

  // Priority: clear > handshake > accept (reset handled in the register).
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_q;
    if (clear) begin
      state_nxt = FILL;
      fill_nxt  = '0;
    end else if (handshake) begin
      state_nxt = FILL;
      fill_nxt  = '0;
    end else if (accept) begin
      fill_nxt = fill_q + 1'b1;
      if (last) state_nxt = FULL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= FILL;
      fill_q <= '0;
    end else begin
      state  <= state_nxt;
      fill_q <= fill_nxt;
    end
  end

  // Frame entries are only written on accept; handshake and clear leave them
  // in place so the next frame simply overwrites them.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
    end else if (accept && !clear) begin
      for (int i = 0; i < neurons; i++)
        if (fill_q == (IDXW+1)'(i)) data_q[i] <= bus.in_data;
    end
  end

`ifdef NEURON_FRAME_LOADER_MAX_TRACK_EN
  // Strictly-greater update keeps the lowest index on ties; entry 0 always
  // reloads so a stale maximum from the previous frame never leaks in.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (accept) begin
      if (fill_q == '0 || bus.in_data > max_val) begin
        max_val <= bus.in_data;
        max_idx <= fill_q[IDXW-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_neuron_frame_loader.sv
module tb_neuron_frame_loader;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset, enable, clear;
  always #5 clock = ~clock;

  neuron_frame_loader_if #(.neurons(N)) bus();

`ifdef NEURON_FRAME_LOADER_MAX_TRACK_EN
  logic [7:0] max_val;
  logic [1:0] max_idx;
`endif

  neuron_frame_loader #(.neurons(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .clear  (clear),
    .bus    (bus)
`ifdef NEURON_FRAME_LOADER_MAX_TRACK_EN
    ,
    .max_val(max_val),
    .max_idx(max_idx)
`endif
  );

  typedef struct {
    logic [0:N-1][7:0] data;
    logic [7:0]        mval;
    logic [1:0]        midx;
  } frame_t;

  frame_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, b, c, d, input logic [7:0] mv, input logic [1:0] mi);
    frame_t f;
    f.data = {a, b, c, d};
    f.mval = mv;
    f.midx = mi;
    exp_q.push_back(f);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every frame taken by the consumer is compared against the queue.
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 64'(bus.out_data), 64'hDEAD);
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        chk("frame_data", 64'(bus.out_data), 64'(f.data));
`ifdef NEURON_FRAME_LOADER_MAX_TRACK_EN
        chk("frame_max_val", 64'(max_val), 64'(f.mval));
        chk("frame_max_idx", 64'(max_idx), 64'(f.midx));
`endif
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    // reset state
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_fill", 64'(bus.fill_count), 0);
    chk("rst_data", 64'(bus.out_data), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 1);

    // continuous stream 10,20,30,40
    push(8'd10, 8'd20, 8'd30, 8'd40, 8'd40, 2'd3);
    bus.in_valid = 1'b1;
    bus.in_data = 8'd10; tick();
    chk("fill_after_1", 64'(bus.fill_count), 1);
    bus.in_data = 8'd20; tick();
    bus.in_data = 8'd30; tick();
    chk("out_valid_before_last", 64'(bus.out_valid), 0);
    bus.in_data = 8'd40; tick();
    chk("full_out_valid", 64'(bus.out_valid), 1);
    chk("full_fill", 64'(bus.fill_count), 4);
    chk("full_in_ready", 64'(bus.in_ready), 0);
    chk("full_data", 64'(bus.out_data), 64'h0A141E28);

    // hold in FULL with 99 offered: nothing may change
    bus.in_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_data", 64'(bus.out_data), 64'h0A141E28);
      chk("hold_valid", 64'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    chk("post_hs_valid", 64'(bus.out_valid), 0);
    chk("post_hs_fill", 64'(bus.fill_count), 0);
    chk("post_hs_in_ready", 64'(bus.in_ready), 1);

    // second frame 99,5,<stall 2>,6,7
    push(8'd99, 8'd5, 8'd6, 8'd7, 8'd99, 2'd0);
    tick();
    chk("entry0_99", 64'(bus.out_data[0]), 64'd99);
    chk("fill_1", 64'(bus.fill_count), 1);
    bus.in_data = 8'd5; tick();
    enable = 1'b0; bus.in_data = 8'd6;
    #1 chk("stall_in_ready", 64'(bus.in_ready), 0);
    tick(); chk("stall_fill_a", 64'(bus.fill_count), 2);
    tick(); chk("stall_fill_b", 64'(bus.fill_count), 2);
    enable = 1'b1; tick();
    bus.in_data = 8'd7; tick();
    bus.in_valid = 1'b0;
    chk("stall_frame_valid", 64'(bus.out_valid), 1);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

    // clear mid-frame with 55 offered
    bus.in_valid = 1'b1;
    bus.in_data = 8'd8; tick();
    bus.in_data = 8'd9; tick();
    clear = 1'b1; bus.in_data = 8'd55; tick();
    clear = 1'b0; bus.in_valid = 1'b0;
    chk("clr_fill", 64'(bus.fill_count), 0);
    chk("clr_valid", 64'(bus.out_valid), 0);
    chk("clr_entry2_kept", 64'(bus.out_data[2]), 64'd6);
    chk("clr_entry0_kept", 64'(bus.out_data[0]), 64'd8);
`ifdef NEURON_FRAME_LOADER_MAX_TRACK_EN
    chk("clr_max_val", 64'(max_val), 0);
    chk("clr_max_idx", 64'(max_idx), 0);
`endif
    push(8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 2'd3);
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = 8'(i); tick();
    end
    bus.in_valid = 1'b0;
    chk("clr_frame_valid", 64'(bus.out_valid), 1);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

    // ties keep lowest index
    push(8'd7, 8'd200, 8'd200, 8'd3, 8'd200, 2'd1);
    bus.in_valid = 1'b1;
    bus.in_data = 8'd7;   tick();
    bus.in_data = 8'd200; tick();
    bus.in_data = 8'd200; tick();
    bus.in_data = 8'd3;   tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
`ifdef NEURON_FRAME_LOADER_MAX_TRACK_EN
    chk("max_kept_after_hs", 64'(max_val), 64'd200);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("max_clr_val", 64'(max_val), 0);
    chk("max_clr_idx", 64'(max_idx), 0);
`endif

    // reset wins over simultaneous handshake
    bus.in_valid = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      bus.in_data = 8'(i); tick();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 64'(bus.out_valid), 1);
    reset = 1'b1; bus.out_ready = 1'b1; tick();
    reset = 1'b0; bus.out_ready = 1'b0;
    chk("rst_hs_valid", 64'(bus.out_valid), 0);
    chk("rst_hs_fill", 64'(bus.fill_count), 0);
    chk("rst_hs_data", 64'(bus.out_data), 0);
    chk("rst_hs_in_ready", 64'(bus.in_ready), 1);

    tick();
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
